matrix_display_reader: RTL and testbench

//  Read-side counterpart of the matrix storage write path. In display mode it walks every stored

---
 rtl/matrix_display_reader_if.sv | 44 ++++
 rtl/matrix_display_reader.sv | 211 +++++++++++++++++++++
 tb/tb_matrix_display_reader.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_display_reader_if.sv
// Bus bundle between matrix_display_reader and its neighbours: storage read port,
// matrix printer handshake and UART TX byte path.
interface matrix_display_reader_if #(
   parameter int unsigned FLAT_W = 200
) ();
   // Storage read port
   logic              read_en;
   logic [2:0]        rd_row;
   logic [2:0]        rd_col;
   logic [1:0]        rd_mat_index;
   logic [FLAT_W-1:0] rd_data_flow;
   logic              rd_ready;
   logic              err_rd;

   // Matrix printer
   logic              prt_start;
   logic [FLAT_W-1:0] prt_flat;
   logic [2:0]        prt_m;
   logic [2:0]        prt_n;
   logic              prt_done;

   // UART TX
   logic              tx_start;
   logic [7:0]        tx_data;
   logic              tx_busy;

   modport master (
      output read_en, rd_row, rd_col, rd_mat_index,
      input  rd_data_flow, rd_ready, err_rd,
      output prt_start, prt_flat, prt_m, prt_n,
      input  prt_done,
      output tx_start, tx_data,
      input  tx_busy
   );

   modport slave (
      input  read_en, rd_row, rd_col, rd_mat_index,
      output rd_data_flow, rd_ready, err_rd,
      input  prt_start, prt_flat, prt_m, prt_n,
      output prt_done,
      input  tx_start, tx_data,
      output tx_busy
   );
endinterface

// File: rtl/matrix_display_reader.sv
// Walks all storage slots of one requested dimension and hands each stored matrix to the printer.
// Define MATRIX_HEADER_EN to emit a "#k\r\n" index line on UART TX before each printed matrix.
module matrix_display_reader #(
   parameter int unsigned MAXNUM     = 2,
   parameter int unsigned FLAT_W     = 200,
   parameter int unsigned RD_TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_i,
   input  logic                      abort_i,
   input  logic [2:0]                req_m_i,
   input  logic [2:0]                req_n_i,
   matrix_display_reader_if.master   bus,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      none_found_o,
   output logic [3:0]                found_cnt_o
);

   localparam int unsigned TmoW = $clog2(RD_TIMEOUT + 1);

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWaitRd,
      StHdr,
      StPrtStart,
      StPrtWait,
      StNext,
      StFinish
   } state_e;

   state_e            state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic [3:0]        found_q, found_d;
   logic [2:0]        m_q, m_d;
   logic [2:0]        n_q, n_d;
   logic [FLAT_W-1:0] flat_q, flat_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;
   logic              bad_dim_q, bad_dim_d;
   logic              dim_ok;
   logic              none_fin;

`ifdef MATRIX_HEADER_EN
   logic [2:0]        hb_q, hb_d;
   logic              guard_q, guard_d;
   logic [7:0]        hdr_byte;

   always_comb begin
      hdr_byte = 8'h00;
      unique case (hb_q[1:0])
         2'd0:    hdr_byte = 8'h23;
         2'd1:    hdr_byte = 8'h31 + 8'(idx_q);
         2'd2:    hdr_byte = 8'h0D;
         default: hdr_byte = 8'h0A;
      endcase
   end
`else
   logic              unused_tx_busy;
   assign unused_tx_busy = bus.tx_busy;
`endif

   assign dim_ok = (req_m_i >= 3'd1) && (req_m_i <= 3'd5) &&
                   (req_n_i >= 3'd1) && (req_n_i <= 3'd5);

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      found_d       = found_q;
      m_d           = m_q;
      n_d           = n_q;
      flat_d        = flat_q;
      tmo_d         = tmo_q;
      bad_dim_d     = 1'b0;
      bus.read_en   = 1'b0;
      bus.prt_start = 1'b0;
      bus.tx_start  = 1'b0;
      bus.tx_data   = 8'h00;
      done_o        = 1'b0;
      none_fin      = 1'b0;
`ifdef MATRIX_HEADER_EN
      hb_d          = hb_q;
      guard_d       = guard_q;
`endif
      // Abort wins over every state action, so no strobe leaks out in the abort cycle.
      if ((state_q != StIdle) && abort_i) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  if (dim_ok) begin
                     m_d     = req_m_i;
                     n_d     = req_n_i;
                     idx_d   = 4'd0;
                     found_d = 4'd0;
                     state_d = StReq;
                  end else begin
                     bad_dim_d = 1'b1;
                  end
               end
            end
            StReq: begin
               bus.read_en = 1'b1;
               tmo_d       = '0;
               state_d     = StWaitRd;
            end
            StWaitRd: begin
               if (bus.err_rd) begin
                  state_d = StNext;
               end else if (bus.rd_ready) begin
                  flat_d  = bus.rd_data_flow;
`ifdef MATRIX_HEADER_EN
                  hb_d    = 3'd0;
                  guard_d = 1'b0;
                  state_d = StHdr;
`else
                  state_d = StPrtStart;
`endif
               end else if (tmo_q == TmoW'(RD_TIMEOUT - 1)) begin
                  state_d = StNext;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
`ifdef MATRIX_HEADER_EN
            StHdr: begin
               // One guard cycle after each strobe so a stale tx_busy=0 is never trusted.
               if (guard_q) begin
                  guard_d = 1'b0;
                  if (hb_q == 3'd4) begin
                     state_d = StPrtStart;
                  end
               end else if (!bus.tx_busy) begin
                  bus.tx_start = 1'b1;
                  bus.tx_data  = hdr_byte;
                  hb_d         = hb_q + 3'd1;
                  guard_d      = 1'b1;
               end
            end
`endif
            StPrtStart: begin
               bus.prt_start = 1'b1;
               state_d       = StPrtWait;
            end
            StPrtWait: begin
               if (bus.prt_done) begin
                  found_d = found_q + 4'd1;
                  state_d = StNext;
               end
            end
            StNext: begin
               if (idx_q == 4'(MAXNUM - 1)) begin
                  state_d = StFinish;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = StReq;
               end
            end
            StFinish: begin
               done_o   = (found_q != 4'd0);
               none_fin = (found_q == 4'd0);
               state_d  = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         idx_q     <= 4'd0;
         found_q   <= 4'd0;
         m_q       <= 3'd0;
         n_q       <= 3'd0;
         flat_q    <= '0;
         tmo_q     <= '0;
         bad_dim_q <= 1'b0;
`ifdef MATRIX_HEADER_EN
         hb_q      <= 3'd0;
         guard_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         found_q   <= found_d;
         m_q       <= m_d;
         n_q       <= n_d;
         flat_q    <= flat_d;
         tmo_q     <= tmo_d;
         bad_dim_q <= bad_dim_d;
`ifdef MATRIX_HEADER_EN
         hb_q      <= hb_d;
         guard_q   <= guard_d;
`endif
      end
   end

   assign bus.rd_row       = m_q;
   assign bus.rd_col       = n_q;
   assign bus.rd_mat_index = idx_q[1:0];
   assign bus.prt_flat     = flat_q;
   assign bus.prt_m        = m_q;
   assign bus.prt_n        = n_q;
   assign busy_o           = (state_q != StIdle) && (state_q != StFinish);
   assign none_found_o     = none_fin | bad_dim_q;
   assign found_cnt_o      = found_q;

endmodule

// File: tb/tb_matrix_display_reader.sv
// Randomized bench for matrix_display_reader: storage, printer and UART models plus a
// slot-level reference model of which matrices must be printed and in what order.
module tb_matrix_display_reader;

   localparam int unsigned MaxNum    = 2;
   localparam int unsigned FlatW     = 200;
   localparam int unsigned RdTimeout = 16;
`ifdef MATRIX_HEADER_EN
   localparam bit HdrEn = 1'b1;
`else
   localparam bit HdrEn = 1'b0;
`endif

   // Slot behaviour: 0 data, 1 err_rd, 2 silent, 3 rd_ready and err_rd together
   localparam int ModeData = 0, ModeErr = 1, ModeSilent = 2, ModeBoth = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [2:0] req_m = 3'd0;
   logic [2:0] req_n = 3'd0;
   logic       busy_o, done_o, none_found_o;
   logic [3:0] found_cnt_o;

   matrix_display_reader_if #(.FLAT_W(FlatW)) bus ();

   matrix_display_reader #(
      .MAXNUM    (MaxNum),
      .FLAT_W    (FlatW),
      .RD_TIMEOUT(RdTimeout)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start),
      .abort_i     (abort),
      .req_m_i     (req_m),
      .req_n_i     (req_n),
      .bus         (bus),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .none_found_o(none_found_o),
      .found_cnt_o (found_cnt_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [FlatW-1:0] rand_flat();
      logic [223:0] t;
      for (int w = 0; w < 7; w++) t[w*32 +: 32] = $urandom;
      return t[FlatW-1:0];
   endfunction

   // Environment state
   int                slot_mode [MaxNum];
   logic [FlatW-1:0]  slot_data [MaxNum];
   int                prt_lo = 0, prt_hi = 5;
   logic [7:0]        got_rd [$];
   logic [FlatW-1:0]  got_prt [$];
   logic [7:0]        got_prt_dim [$];
   logic [7:0]        got_tx [$];
   int                tx_at_prt [$];
   int                done_seen, none_seen, tx_viol, stab_err;
   logic              busy_at_end;

   initial begin
      int               rd_pend, rd_wait, rd_slot, prt_pend, prt_wait, tx_left;
      logic [FlatW-1:0] prt_cap;
      rd_pend = 0; rd_wait = 0; rd_slot = 0; prt_pend = 0; prt_wait = 0; tx_left = 0;
      prt_cap = '0;
      bus.rd_ready = 1'b0; bus.err_rd = 1'b0; bus.rd_data_flow = '0;
      bus.prt_done = 1'b0; bus.tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.read_en) begin
            got_rd.push_back({bus.rd_mat_index, bus.rd_row, bus.rd_col});
            rd_pend = 1;
            rd_slot = int'(bus.rd_mat_index);
            rd_wait = $urandom_range(0, 6);
         end
         if (prt_pend != 0 && busy_o && bus.prt_flat !== prt_cap) stab_err++;
         if (bus.prt_start) begin
            got_prt.push_back(bus.prt_flat);
            got_prt_dim.push_back({2'b00, bus.prt_m, bus.prt_n});
            tx_at_prt.push_back(got_tx.size());
            prt_cap  = bus.prt_flat;
            prt_pend = 1;
            prt_wait = $urandom_range(prt_lo, prt_hi);
         end
         if (bus.tx_start) begin
            got_tx.push_back(bus.tx_data);
            if (bus.tx_busy) tx_viol++;
            tx_left = 3;
         end
         if (done_o) begin done_seen++; busy_at_end = busy_o; end
         if (none_found_o) begin none_seen++; busy_at_end = busy_o; end
         @(posedge clk);
         #1;
         bus.rd_ready     = 1'b0;
         bus.err_rd       = 1'b0;
         bus.prt_done     = 1'b0;
         bus.rd_data_flow = rand_flat();
         if (rd_pend != 0) begin
            if (rd_wait == 0) begin
               rd_pend = 0;
               if (rd_slot < MaxNum) begin
                  case (slot_mode[rd_slot])
                     ModeData: begin bus.rd_ready = 1'b1; bus.rd_data_flow = slot_data[rd_slot]; end
                     ModeErr:  bus.err_rd = 1'b1;
                     ModeBoth: begin
                        bus.rd_ready = 1'b1; bus.err_rd = 1'b1;
                        bus.rd_data_flow = slot_data[rd_slot];
                     end
                     default: ;
                  endcase
               end
            end else begin
               rd_wait--;
            end
         end
         if (prt_pend != 0) begin
            if (prt_wait == 0) begin
               prt_pend = 0;
               bus.prt_done = 1'b1;
            end else begin
               prt_wait--;
            end
         end
         bus.tx_busy = (tx_left > 0);
         if (tx_left > 0) tx_left--;
      end
   end

   task automatic clear_mon();
      got_rd.delete(); got_prt.delete(); got_prt_dim.delete(); got_tx.delete();
      tx_at_prt.delete();
      done_seen = 0; none_seen = 0; tx_viol = 0; stab_err = 0; busy_at_end = 1'b1;
   endtask

   task automatic pulse_start(input logic [2:0] m, input logic [2:0] n);
      @(posedge clk); #1;
      req_m = m; req_n = n; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic set_slots(input int m0, input int m1);
      slot_mode[0] = m0; slot_mode[1] = m1;
      for (int i = 0; i < MaxNum; i++) slot_data[i] = rand_flat();
   endtask

   // Reference: every slot is read in order; only slots answering rd_ready alone get printed.
   task automatic run_listing(input logic [2:0] m, input logic [2:0] n, input string name);
      logic [FlatW-1:0] exp_prt [$];
      int               exp_idx [$];
      logic [7:0]       exp_tx [$];
      int               lim;
      for (int i = 0; i < MaxNum; i++) begin
         if (slot_mode[i] == ModeData) begin
            exp_prt.push_back(slot_data[i]);
            exp_idx.push_back(i);
         end
      end
      if (HdrEn) begin
         foreach (exp_idx[k]) begin
            exp_tx.push_back(8'h23);
            exp_tx.push_back(8'h31 + 8'(exp_idx[k]));
            exp_tx.push_back(8'h0D);
            exp_tx.push_back(8'h0A);
         end
      end
      clear_mon();
      pulse_start(m, n);
      @(negedge clk);
      check_eq({name, ":busy_after_start"}, busy_o, 1'b1);
      for (int c = 0; c < 600; c++) begin
         if (done_seen + none_seen > 0) break;
         @(negedge clk);
      end
      check_eq({name, ":end_pulse"}, done_seen + none_seen, 1);
      check_eq({name, ":done"}, done_seen, (exp_prt.size() > 0) ? 1 : 0);
      check_eq({name, ":none_found"}, none_seen, (exp_prt.size() == 0) ? 1 : 0);
      check_eq({name, ":busy_at_end"}, busy_at_end, 1'b0);
      check_eq({name, ":found_cnt"}, found_cnt_o, exp_prt.size());
      check_eq({name, ":reads"}, got_rd.size(), MaxNum);
      lim = (got_rd.size() < MaxNum) ? got_rd.size() : MaxNum;
      for (int i = 0; i < lim; i++)
         check_eq($sformatf("%s:read%0d", name, i), got_rd[i], {2'(i), m, n});
      check_eq({name, ":prints"}, got_prt.size(), exp_prt.size());
      lim = (got_prt.size() < exp_prt.size()) ? got_prt.size() : exp_prt.size();
      for (int k = 0; k < lim; k++) begin
         check_eq($sformatf("%s:prt_data%0d", name, k), got_prt[k], exp_prt[k]);
         check_eq($sformatf("%s:prt_dim%0d", name, k), got_prt_dim[k], {2'b00, m, n});
         check_eq($sformatf("%s:tx_before_prt%0d", name, k), tx_at_prt[k], HdrEn ? 4*(k+1) : 0);
      end
      check_eq({name, ":tx_bytes"}, got_tx.size(), exp_tx.size());
      lim = (got_tx.size() < exp_tx.size()) ? got_tx.size() : exp_tx.size();
      for (int b = 0; b < lim; b++)
         check_eq($sformatf("%s:tx%0d", name, b), got_tx[b], exp_tx[b]);
      check_eq({name, ":tx_while_busy"}, tx_viol, 0);
      check_eq({name, ":prt_flat_stable"}, stab_err, 0);
      repeat (4) @(negedge clk);
   endtask

   task automatic illegal_start(input logic [2:0] m, input logic [2:0] n, input string name);
      int saw_busy;
      clear_mon();
      pulse_start(m, n);
      @(negedge clk);
      check_eq({name, ":none_found"}, none_found_o, 1'b1);
      saw_busy = busy_o ? 1 : 0;
      repeat (6) begin
         @(negedge clk);
         if (busy_o) saw_busy = 1;
      end
      check_eq({name, ":busy_stays_0"}, saw_busy, 0);
      check_eq({name, ":no_read"}, got_rd.size(), 0);
      check_eq({name, ":pulse_once"}, none_seen, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      set_slots(ModeData, ModeData);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_eq("reset:busy", busy_o, 1'b0);
      check_eq("reset:done", done_o, 1'b0);
      check_eq("reset:none_found", none_found_o, 1'b0);
      check_eq("reset:found_cnt", found_cnt_o, 4'd0);
      check_eq("reset:read_en", bus.read_en, 1'b0);
      check_eq("reset:prt_start", bus.prt_start, 1'b0);
      check_eq("reset:tx_start", bus.tx_start, 1'b0);
      check_eq("reset:tx_data", bus.tx_data, 8'h00);
      check_eq("reset:prt_flat", bus.prt_flat, '0);

      set_slots(ModeData, ModeData);
      run_listing(3'd3, 3'd3, "two_3x3");
      set_slots(ModeErr, ModeData);
      run_listing(3'd2, 3'd4, "slot1_only");
      set_slots(ModeSilent, ModeSilent);
      run_listing(3'd3, 3'd3, "timeout");
      set_slots(ModeBoth, ModeData);
      run_listing(3'd5, 3'd1, "err_wins");

      illegal_start(3'd0, 3'd3, "illegal_m0");
      illegal_start(3'd6, 3'd3, "illegal_m6");
      illegal_start(3'd2, 3'd7, "illegal_n7");

      // Abort while the printer is busy
      set_slots(ModeData, ModeData);
      prt_lo = 12; prt_hi = 12;
      clear_mon();
      pulse_start(3'd3, 3'd3);
      for (int c = 0; c < 100; c++) begin
         if (got_prt.size() > 0) break;
         @(negedge clk);
      end
      check_eq("abort:reached_prt", got_prt.size(), 1);
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      check_eq("abort:busy", busy_o, 1'b0);
      repeat (30) @(negedge clk);
      check_eq("abort:no_done", done_seen, 0);
      check_eq("abort:no_none", none_seen, 0);
      check_eq("abort:no_more_reads", got_rd.size(), 1);
      check_eq("abort:found_cnt", found_cnt_o, 4'd0);
      prt_lo = 0; prt_hi = 5;
      set_slots(ModeData, ModeErr);
      run_listing(3'd4, 3'd4, "after_abort");

      // Asynchronous reset while the second matrix is being printed
      set_slots(ModeData, ModeData);
      prt_lo = 10; prt_hi = 10;
      clear_mon();
      pulse_start(3'd1, 3'd2);
      for (int c = 0; c < 200; c++) begin
         if (got_prt.size() > 1) break;
         @(negedge clk);
      end
      check_eq("rst_mid:reached_2nd", got_prt.size(), 2);
      check_eq("rst_mid:found_partial", found_cnt_o, 4'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_mid:found_cnt", found_cnt_o, 4'd0);
      check_eq("rst_mid:busy", busy_o, 1'b0);
      check_eq("rst_mid:prt_flat", bus.prt_flat, '0);
      check_eq("rst_mid:prt_m", bus.prt_m, 3'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(negedge clk);
      prt_lo = 0; prt_hi = 5;

      for (int it = 0; it < 10; it++) begin
         logic [2:0] m, n;
         m = 3'($urandom_range(1, 5));
         n = 3'($urandom_range(1, 5));
         set_slots($urandom_range(0, 3), $urandom_range(0, 3));
         run_listing(m, n, $sformatf("rand%0d", it));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
